biasb_ctrl: RTL and testbench

BIASB_CTRL -- requirements
Module: biasb_ctrl

---
 rtl/biasb_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_biasb_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/biasb_ctrl.sv
// biasb_ctrl: loads a bias table into a 2-port SRAM at (base+n) mod DP, then serves indexed reads in order.
// Read latency is 1 cycle. At most 2 reads are outstanding, and rd_ready backpressure holds the request side.

module biasb_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   cnt
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;

   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop)  rp <= rp + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (!push && pop)
            cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wp] <= push_dat;
   end

   assign head = mem[rp];
endmodule

module biasb_ctrl #(
   parameter int AW = 7,
   parameter int DW = 512
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [AW-1:0]     cfg_base,
   input  logic [AW:0]       cfg_len,
   output logic              busy,
   output logic              done,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DW-1:0]     wr_data,
   input  logic [DW/8-1:0]   wr_be,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [AW-1:0]     rd_req_idx,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DW-1:0]     rd_data,
   output logic              rd_err,
   output logic              sram_ena,
   output logic              sram_wea,
   output logic [DW/8-1:0]   sram_be,
   output logic [AW-1:0]     sram_addra,
   output logic [DW-1:0]     sram_dina,
   output logic              sram_enb,
   output logic [AW-1:0]     sram_addrb,
   input  logic [DW-1:0]     sram_doutb
);
   localparam logic [AW:0] DP = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic [AW:0]   wr_cnt;
   logic          start_ok;
   logic          wr_hs;
   logic          last_beat;
   logic          rd_legal;

   logic          infl;
   logic          infl_err;
   logic [AW:0]   idx_ext;
   logic          rd_accept;
   logic          rd_hit;
   logic [1:0]    fifo_cnt;
   logic          fifo_empty;
   logic          fifo_push;
   logic          fifo_pop;
   logic [DW:0]   fifo_head;
   logic [DW:0]   resp;
   logic [1:0]    pending;
   logic          pop_any;
   logic          credit_ok;

   assign start_ok  = cfg_start && (cfg_len != '0) && (state != LOAD);
   assign wr_hs     = (state == LOAD) && wr_valid;
   assign last_beat = wr_hs && (wr_cnt == len - 1'b1);
   assign idx_ext   = {1'b0, rd_req_idx};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      wr_ready  = 1'b0;
      rd_legal  = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = LOAD;
         end
         LOAD: begin
            busy     = 1'b1;
            wr_ready = 1'b1;
            rd_legal = (idx_ext < wr_cnt);
            if (last_beat) state_nxt = READY;
         end
         READY: begin
            rd_legal = 1'b1;
            if (start_ok) state_nxt = LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base   <= '0;
         len    <= '0;
         wr_cnt <= '0;
         done   <= 1'b0;
      end else begin
         done <= last_beat;
         if (start_ok) begin
            base   <= cfg_base;
            len    <= (cfg_len > DP) ? DP : cfg_len;
            wr_cnt <= '0;
         end else if (wr_hs) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
      end
   end

   // Write port: the stream goes straight to the SRAM, so the carry out of base+wr_cnt drops naturally.
   assign sram_ena   = wr_hs;
   assign sram_wea   = wr_hs;
   assign sram_addra = base + wr_cnt[AW-1:0];
   assign sram_be    = wr_be;
   assign sram_dina  = wr_data;

   // The in-flight read counts as a FIFO slot, so the credit limit never overflows the 2-entry FIFO.
   assign pending      = {1'b0, infl} + fifo_cnt;
   assign pop_any      = rd_valid && rd_ready;
   assign credit_ok    = (pending - {1'b0, pop_any}) < 2'd2;
   assign rd_req_ready = rd_legal && credit_ok;
   assign rd_accept    = rd_req_valid && rd_req_ready;
   assign rd_hit       = rd_accept && (idx_ext < len);
   assign sram_enb     = rd_hit;
   assign sram_addrb   = base + rd_req_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         infl     <= 1'b0;
         infl_err <= 1'b0;
      end else begin
         infl     <= rd_accept;
         infl_err <= rd_accept && !rd_hit;
      end
   end

   // An empty FIFO is bypassed so the SRAM output is presented the cycle after the request.
   assign resp       = infl ? {infl_err, (infl_err ? {DW{1'b0}} : sram_doutb)} : '0;
   assign fifo_empty = (fifo_cnt == 2'd0);
   assign fifo_push  = infl && !(fifo_empty && rd_ready);
   assign fifo_pop   = !fifo_empty && rd_ready;
   assign rd_valid   = infl || !fifo_empty;
   assign {rd_err, rd_data} = fifo_empty ? resp : fifo_head;

   biasb_fifo #(.W(DW + 1), .DEPTH(2)) u_resp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .push_dat (resp),
      .pop      (fifo_pop),
      .head     (fifo_head),
      .cnt      (fifo_cnt)
   );
endmodule

// File: tb/tb_biasb_ctrl.sv
// Directed bench for biasb_ctrl: per-cycle vector table plus hand sequences for wrap, stall, credit and reset.
module tb_biasb_ctrl;
   localparam int AW = 7;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_start;
   logic [AW-1:0] cfg_base;
   logic [AW:0]   cfg_len;
   logic          busy, done;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          rd_req_valid, rd_req_ready;
   logic [AW-1:0] rd_req_idx;
   logic          rd_valid, rd_ready;
   logic [DW-1:0] rd_data;
   logic          rd_err;
   logic          sram_ena, sram_wea, sram_enb;
   logic [3:0]    sram_be;
   logic [AW-1:0] sram_addra, sram_addrb;
   logic [DW-1:0] sram_dina, sram_doutb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   biasb_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
      .busy(busy), .done(done), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .wr_be(wr_be), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_idx(rd_req_idx), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_err(rd_err), .sram_ena(sram_ena), .sram_wea(sram_wea), .sram_be(sram_be),
      .sram_addra(sram_addra), .sram_dina(sram_dina), .sram_enb(sram_enb),
      .sram_addrb(sram_addrb), .sram_doutb(sram_doutb)
   );

   // Behavioural 2-port SRAM, 1-cycle read latency, byte-enabled writes.
   logic [DW-1:0] mem [128];
   always @(posedge clk) begin
      if (sram_ena && sram_wea)
         for (int b = 0; b < 4; b++)
            if (sram_be[b]) mem[sram_addra][b*8 +: 8] <= sram_dina[b*8 +: 8];
      if (sram_enb) sram_doutb <= mem[sram_addrb];
   end

   typedef struct {
      logic start; logic [6:0] base; logic [7:0] len;
      logic wv; logic [31:0] wd; logic rqv; logic [6:0] rqi; logic rr;
      logic busy; logic done; logic wrdy; logic qrdy; logic rv; logic rerr;
      logic [31:0] rdat; logic ena; logic [6:0] addra; logic enb; logic [6:0] addrb;
   } vec_t;

   vec_t tbl [12];

   function automatic vec_t mk(input int st, input int bs, input int ln, input int wv,
                               input logic [31:0] wd, input int rqv, input int rqi, input int rr,
                               input int bsy, input int dn, input int wrdy, input int qrdy,
                               input int rv, input int rerr, input logic [31:0] rdat,
                               input int ena, input int addra, input int enb, input int addrb);
      vec_t r;
      r.start = 1'(st);  r.base = 7'(bs);   r.len = 8'(ln);
      r.wv = 1'(wv);     r.wd = wd;         r.rqv = 1'(rqv);  r.rqi = 7'(rqi);  r.rr = 1'(rr);
      r.busy = 1'(bsy);  r.done = 1'(dn);   r.wrdy = 1'(wrdy); r.qrdy = 1'(qrdy);
      r.rv = 1'(rv);     r.rerr = 1'(rerr); r.rdat = rdat;
      r.ena = 1'(ena);   r.addra = 7'(addra); r.enb = 1'(enb); r.addrb = 7'(addrb);
      return r;
   endfunction

   function automatic logic [31:0] dv(input logic [15:0] tag, input int k);
      return {tag, 16'(k)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      cfg_start = 0; cfg_base = '0; cfg_len = '0; wr_valid = 0; wr_data = '0; wr_be = 4'hF;
      rd_req_valid = 0; rd_req_idx = '0; rd_ready = 0;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      // Base 0, len 4 load with reads during and after, out-of-range read, zero-length start.
      tbl[0]  = mk(0,0,0, 0,0,          0,0,0, 0,0,0,0,0,0,0,          0,0,0,0);
      tbl[1]  = mk(1,0,4, 0,0,          0,0,0, 0,0,0,0,0,0,0,          0,0,0,0);
      tbl[2]  = mk(0,0,0, 1,dv(16'h1111,0), 1,0,0, 1,0,1,0,0,0,0,      1,0,0,0);
      tbl[3]  = mk(0,0,0, 1,dv(16'h1111,1), 1,0,1, 1,0,1,1,0,0,0,      1,1,1,0);
      tbl[4]  = mk(0,0,0, 1,dv(16'h1111,2), 0,1,1, 1,0,1,1,1,0,dv(16'h1111,0), 1,2,0,0);
      tbl[5]  = mk(0,0,0, 1,dv(16'h1111,3), 0,3,1, 1,0,1,0,0,0,0,      1,3,0,0);
      tbl[6]  = mk(0,0,0, 1,dv(16'h1111,7), 1,9,1, 0,1,0,1,0,0,0,      0,0,0,0);
      tbl[7]  = mk(0,0,0, 0,0,          1,3,1, 0,0,0,1,1,1,0,          0,0,1,3);
      tbl[8]  = mk(0,0,0, 0,0,          1,1,1, 0,0,0,1,1,0,dv(16'h1111,3), 0,0,1,1);
      tbl[9]  = mk(0,0,0, 0,0,          0,0,1, 0,0,0,1,1,0,dv(16'h1111,1), 0,0,0,0);
      tbl[10] = mk(1,5,0, 0,0,          0,0,1, 0,0,0,1,0,0,0,          0,0,0,0);
      tbl[11] = mk(0,0,0, 0,0,          0,5,1, 0,0,0,1,0,0,0,          0,0,0,0);

      zero_inputs();
      rst = 1;
      cyc(); cyc();
      chk("reset_outputs", 32'({busy, done, wr_ready, rd_req_ready, rd_valid, rd_err,
                                sram_ena, sram_wea, sram_enb}), 32'd0);
      rst = 0;

      for (int i = 0; i < 12; i++) begin
         cfg_start = tbl[i].start; cfg_base = tbl[i].base; cfg_len = tbl[i].len;
         wr_valid = tbl[i].wv; wr_data = tbl[i].wd;
         rd_req_valid = tbl[i].rqv; rd_req_idx = tbl[i].rqi; rd_ready = tbl[i].rr;
         @(negedge clk);
         chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
         chk($sformatf("v%0d.done", i), 32'(done), 32'(tbl[i].done));
         chk($sformatf("v%0d.wr_ready", i), 32'(wr_ready), 32'(tbl[i].wrdy));
         chk($sformatf("v%0d.rd_req_ready", i), 32'(rd_req_ready), 32'(tbl[i].qrdy));
         chk($sformatf("v%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
         chk($sformatf("v%0d.sram_ena", i), 32'(sram_ena), 32'(tbl[i].ena));
         chk($sformatf("v%0d.sram_enb", i), 32'(sram_enb), 32'(tbl[i].enb));
         if (tbl[i].rv) begin
            chk($sformatf("v%0d.rd_err", i), 32'(rd_err), 32'(tbl[i].rerr));
            chk($sformatf("v%0d.rd_data", i), rd_data, tbl[i].rdat);
         end
         if (tbl[i].ena) chk($sformatf("v%0d.sram_addra", i), 32'(sram_addra), 32'(tbl[i].addra));
         if (tbl[i].enb) chk($sformatf("v%0d.sram_addrb", i), 32'(sram_addrb), 32'(tbl[i].addrb));
         cyc();
      end
      zero_inputs();

      // Wrapping load: base 126, len 4.
      cfg_start = 1; cfg_base = 7'd126; cfg_len = 8'd4;
      cyc();
      cfg_start = 0;
      for (int k = 0; k < 4; k++) begin
         logic [6:0] ea;
         ea = 7'(126 + k);
         wr_valid = 1; wr_data = dv(16'h2222, k);
         @(negedge clk);
         chk($sformatf("wrap_ena%0d", k), 32'(sram_ena), 32'd1);
         chk($sformatf("wrap_addra%0d", k), 32'(sram_addra), 32'(ea));
         cyc();
      end
      wr_valid = 0;
      @(negedge clk);
      chk("wrap_done", 32'(done), 32'd1);
      chk("wrap_busy", 32'(busy), 32'd0);
      cyc();
      rd_req_valid = 1; rd_req_idx = 7'd3; rd_ready = 1;
      @(negedge clk);
      chk("wrap_rd_enb", 32'({rd_req_ready, sram_enb}), 32'b11);
      chk("wrap_rd_addrb", 32'(sram_addrb), 32'd1);
      cyc();
      rd_req_valid = 0;
      @(negedge clk);
      chk("wrap_rd_valid", 32'(rd_valid), 32'd1);
      chk("wrap_rd_data", rd_data, dv(16'h2222, 3));
      cyc();

      // Read of a not-yet-written row stalls until that row lands; a start during LOAD is ignored.
      cfg_start = 1; cfg_base = 7'd10; cfg_len = 8'd4;
      cyc();
      cfg_start = 0;
      for (int k = 0; k < 2; k++) begin
         wr_valid = 1; wr_data = dv(16'h3333, k);
         cyc();
      end
      wr_valid = 0; rd_req_valid = 1; rd_req_idx = 7'd2; rd_ready = 1;
      @(negedge clk);
      chk("stall_rdy_a", 32'(rd_req_ready), 32'd0);
      cyc();
      wr_valid = 1; wr_data = dv(16'h3333, 2);
      cfg_start = 1; cfg_base = 7'd50; cfg_len = 8'd2;
      @(negedge clk);
      chk("stall_rdy_b", 32'(rd_req_ready), 32'd0);
      chk("stall_addra2", 32'(sram_addra), 32'd12);
      cyc();
      cfg_start = 0; wr_valid = 0;
      @(negedge clk);
      chk("stall_rdy_c", 32'({rd_req_ready, sram_enb}), 32'b11);
      chk("stall_addrb", 32'(sram_addrb), 32'd12);
      cyc();
      rd_req_valid = 0; wr_valid = 1; wr_data = dv(16'h3333, 3);
      @(negedge clk);
      chk("stall_rd_data", rd_data, dv(16'h3333, 2));
      chk("ignored_start_addra", 32'(sram_addra), 32'd13);
      cyc();
      wr_valid = 0;
      @(negedge clk);
      chk("stall_done", 32'(done), 32'd1);
      cyc();

      // Credit limit with rd_ready low, in-order drain, then 1 response per cycle.
      rd_ready = 0; rd_req_valid = 1; rd_req_idx = 7'd0;
      @(negedge clk); chk("cred_acc0", 32'(rd_req_ready), 32'd1); cyc();
      rd_req_idx = 7'd1;
      @(negedge clk); chk("cred_acc1", 32'(rd_req_ready), 32'd1); cyc();
      rd_req_idx = 7'd2;
      @(negedge clk); chk("cred_hold_a", 32'(rd_req_ready), 32'd0); cyc();
      @(negedge clk);
      chk("cred_hold_b", 32'(rd_req_ready), 32'd0);
      chk("cred_stable", rd_data, dv(16'h3333, 0));
      cyc();
      rd_ready = 1;
      @(negedge clk);
      chk("drain0", rd_data, dv(16'h3333, 0));
      chk("cred_acc2", 32'(rd_req_ready), 32'd1);
      cyc();
      rd_req_idx = 7'd3;
      @(negedge clk);
      chk("drain1", rd_data, dv(16'h3333, 1));
      chk("stream_acc3", 32'(rd_req_ready), 32'd1);
      cyc();
      rd_req_idx = 7'd0;
      @(negedge clk);
      chk("drain2", rd_data, dv(16'h3333, 2));
      chk("stream_acc0", 32'(rd_req_ready), 32'd1);
      cyc();
      rd_req_valid = 0;
      @(negedge clk);
      chk("stream3", 32'({rd_valid, rd_err}), 32'b10);
      chk("stream3_data", rd_data, dv(16'h3333, 3));
      cyc();
      @(negedge clk);
      chk("stream4", 32'(rd_valid), 32'd1);
      chk("stream4_data", rd_data, dv(16'h3333, 0));
      cyc();
      @(negedge clk);
      chk("stream_empty", 32'(rd_valid), 32'd0);
      zero_inputs();
      cyc();

      // Reset mid-load with a response pending, then a zero-length start.
      cfg_start = 1; cfg_base = 7'd0; cfg_len = 8'd8;
      cyc();
      cfg_start = 0; wr_valid = 1; wr_data = dv(16'h4444, 0);
      cyc();
      wr_data = dv(16'h4444, 1); rd_req_valid = 1; rd_req_idx = 7'd0; rd_ready = 0;
      @(negedge clk);
      chk("rst_pre_rd", 32'(rd_req_ready), 32'd1);
      cyc();
      rd_req_valid = 0; wr_data = dv(16'h4444, 2); rst = 1;
      cyc();
      rst = 0;
      @(negedge clk);
      chk("rst_mid_outputs", 32'({busy, done, wr_ready, rd_valid, sram_ena}), 32'd0);
      cyc();
      wr_valid = 0;
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
      cfg_start = 1; cfg_len = 8'd0;
      cyc();
      cfg_start = 0; rd_req_valid = 1; rd_req_idx = 7'd0;
      @(negedge clk);
      chk("len0_idle", 32'({busy, wr_ready, rd_req_ready}), 32'd0);
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
